ts_header_check: RTL and testbench

TS_HEADER_CHECK -- requirements
Module: ts_header_check

---
 rtl/ts_header_check.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ts_header_check.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_header_check.sv
// ts_header_check: parses the 4-byte MPEG-TS header from a byte stream,
// tracks continuity counters per PID and keeps saturating statistics.
module ts_header_check #(
    parameter int NUM_PIDS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             pkt_start,
    input  logic             cnt_clr,
    output logic             hdr_valid,
    output logic [12:0]      pid,
    output logic [3:0]       cc,
    output logic             tei,
    output logic             pusi,
    output logic [1:0]       afc,
    output logic             cc_error,
    output logic             sync_loss,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] cc_err_count,
    output logic [CNT_W-1:0] tei_count
);

    localparam logic [7:0]  SYNC_BYTE = 8'h47;
    localparam logic [12:0] NULL_PID  = 13'h1FFF;
    localparam logic [7:0]  LAST_IDX  = 8'd187;
    localparam int          SLOT_W    = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;

    typedef enum logic [2:0] {IDLE, HDR1, HDR2, HDR3, PAYLOAD} state_t;

    state_t      state, state_nxt;
    logic [7:0]  idx, idx_nxt;

    logic        take_hdr1, take_hdr2, take_hdr3;
    logic        sync_err;

    logic        tei_q, pusi_q;
    logic [4:0]  pid_hi_q;
    logic [7:0]  pid_lo_q;
    logic [12:0] pid_cur;
    logic [3:0]  cc_cur;
    logic [1:0]  afc_cur;

    logic [NUM_PIDS-1:0] slot_vld;
    logic [12:0]         slot_pid [NUM_PIDS];
    logic [3:0]          slot_cc  [NUM_PIDS];
    logic                slot_dup [NUM_PIDS];

    logic              hit, free_found, upd, new_dup, cc_bad;
    logic [SLOT_W-1:0] hit_idx, free_idx, upd_idx;

    assign pid_cur = {pid_hi_q, pid_lo_q};
    assign cc_cur  = byte_in[3:0];
    assign afc_cur = byte_in[5:4];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // FSM state register and byte index within the packet
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= 8'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic; idx == 188 in PAYLOAD means "expecting the next sync byte"
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (byte_valid) begin
            if (state == IDLE) begin
                if (pkt_start && byte_in == SYNC_BYTE) begin
                    state_nxt = HDR1;
                    idx_nxt   = 8'd1;
                end
            end else if (pkt_start && byte_in != SYNC_BYTE) begin
                state_nxt = IDLE;
                idx_nxt   = 8'd0;
            end else if (pkt_start) begin
                state_nxt = HDR1;
                idx_nxt   = 8'd1;
            end else begin
                case (state)
                    HDR1: begin
                        state_nxt = HDR2;
                        idx_nxt   = 8'd2;
                    end
                    HDR2: begin
                        state_nxt = HDR3;
                        idx_nxt   = 8'd3;
                    end
                    HDR3: begin
                        state_nxt = PAYLOAD;
                        idx_nxt   = 8'd4;
                    end
                    PAYLOAD: begin
                        if (idx > LAST_IDX) begin
                            state_nxt = IDLE;
                            idx_nxt   = 8'd0;
                        end else begin
                            idx_nxt = idx + 8'd1;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        idx_nxt   = 8'd0;
                    end
                endcase
            end
        end
    end

    // FSM outputs: header capture strobes and framing-violation detect.
    // In IDLE the block is hunting, so a bad sync there is silently ignored.
    always_comb begin
        take_hdr1 = byte_valid && !pkt_start && (state == HDR1);
        take_hdr2 = byte_valid && !pkt_start && (state == HDR2);
        take_hdr3 = byte_valid && !pkt_start && (state == HDR3);
        sync_err  = 1'b0;
        if (byte_valid && state != IDLE) begin
            if (pkt_start)
                sync_err = (byte_in != SYNC_BYTE) || !(state == PAYLOAD && idx > LAST_IDX);
            else
                sync_err = (state == PAYLOAD) && (idx > LAST_IDX);
        end
    end

    // Header field capture from bytes 1 and 2
    always_ff @(posedge clk) begin
        if (take_hdr1) begin
            tei_q    <= byte_in[7];
            pusi_q   <= byte_in[6];
            pid_hi_q <= byte_in[4:0];
        end
        if (take_hdr2)
            pid_lo_q <= byte_in;
    end

    // PID table lookup: matching slot and lowest free slot
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_PIDS - 1; i >= 0; i--) begin
            if (slot_vld[i] && slot_pid[i] == pid_cur) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
            if (!slot_vld[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    // Continuity check; afc without payload must repeat cc, afc with payload
    // may advance by one or repeat once as a duplicate packet
    always_comb begin
        cc_bad  = 1'b0;
        upd     = 1'b0;
        upd_idx = '0;
        new_dup = 1'b0;
        if (pid_cur != NULL_PID && !tei_q) begin
            if (hit) begin
                upd     = 1'b1;
                upd_idx = hit_idx;
                new_dup = slot_dup[hit_idx];
                if (!afc_cur[0]) begin
                    cc_bad = (cc_cur != slot_cc[hit_idx]);
                end else if (cc_cur == slot_cc[hit_idx] + 4'd1) begin
                    new_dup = 1'b0;
                end else if (cc_cur == slot_cc[hit_idx]) begin
                    if (slot_dup[hit_idx])
                        cc_bad = 1'b1;
                    else
                        new_dup = 1'b1;
                end else begin
                    cc_bad  = 1'b1;
                    new_dup = 1'b0;
                end
            end else if (free_found) begin
                upd     = 1'b1;
                upd_idx = free_idx;
                new_dup = 1'b0;
            end
        end
    end

    // Slot valid bits; a counter clear wins over a same-edge allocation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            slot_vld <= '0;
        else if (cnt_clr)
            slot_vld <= '0;
        else if (take_hdr3 && upd)
            slot_vld[upd_idx] <= 1'b1;
    end

    // Slot contents, meaningful only while the slot is valid
    always_ff @(posedge clk) begin
        if (take_hdr3 && upd) begin
            slot_pid[upd_idx] <= pid_cur;
            slot_cc[upd_idx]  <= cc_cur;
            slot_dup[upd_idx] <= new_dup;
        end
    end

    // ---- stage p1: registered header outputs and pulses ----
    // Header outputs and one-cycle pulses, one cycle after the HDR3 byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_valid <= 1'b0;
            cc_error  <= 1'b0;
            sync_loss <= 1'b0;
            pid       <= '0;
            cc        <= '0;
            tei       <= 1'b0;
            pusi      <= 1'b0;
            afc       <= '0;
        end else begin
            hdr_valid <= take_hdr3;
            cc_error  <= take_hdr3 && cc_bad;
            sync_loss <= sync_err;
            if (take_hdr3) begin
                pid  <= pid_cur;
                cc   <= cc_cur;
                tei  <= tei_q;
                pusi <= pusi_q;
                afc  <= afc_cur;
            end
        end
    end

    // ---- stage p2: statistics driven by the registered pulses ----
    // Saturating counters; clear wins over a coincident header pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count    <= '0;
            cc_err_count <= '0;
            tei_count    <= '0;
        end else if (cnt_clr) begin
            pkt_count    <= '0;
            cc_err_count <= '0;
            tei_count    <= '0;
        end else begin
            if (hdr_valid)
                pkt_count <= sat_inc(pkt_count);
            if (hdr_valid && tei)
                tei_count <= sat_inc(tei_count);
            if (cc_error)
                cc_err_count <= sat_inc(cc_err_count);
        end
    end

endmodule

// File: tb/tb_ts_header_check.sv
// Bench for ts_header_check: packet-position reference model plus directed
// scenarios and randomized packet streams.
module tb_ts_header_check;

    localparam int NPID = 8;
    localparam int CW   = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          pkt_start = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          hdr_valid, tei, pusi, cc_error, sync_loss;
    logic [12:0]   pid;
    logic [3:0]    cc;
    logic [1:0]    afc;
    logic [CW-1:0] pkt_count, cc_err_count, tei_count;

    always #5 clk = ~clk;

    ts_header_check #(.NUM_PIDS(NPID), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .pkt_start(pkt_start), .cnt_clr(cnt_clr), .hdr_valid(hdr_valid),
        .pid(pid), .cc(cc), .tei(tei), .pusi(pusi), .afc(afc),
        .cc_error(cc_error), .sync_loss(sync_loss), .pkt_count(pkt_count),
        .cc_err_count(cc_err_count), .tei_count(tei_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_hv = 0, n_ce = 0, n_sl = 0;
    bit gaps = 0, rnd_clr = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pos: -1 hunting for sync, else index of the next byte in the packet (1..188)
    int            pos;
    logic          m_tei, m_pusi;
    logic [12:0]   m_pid;
    logic          e_hv, e_ce, e_sl, e_tei, e_pusi;
    logic [12:0]   e_pid;
    logic [3:0]    e_cc;
    logic [1:0]    e_afc;
    logic [CW-1:0] e_pkt, e_cerr, e_tcnt;
    bit            t_vld [NPID];
    logic [12:0]   t_pid [NPID];
    logic [3:0]    t_cc  [NPID];
    bit            t_dup [NPID];

    function automatic logic [CW-1:0] sinc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + CW'(1);
    endfunction

    task automatic model_header(input logic [3:0] c, input logic [1:0] a);
        int slot, fr;
        bit err;
        logic [3:0] succ;
        slot = -1; fr = -1; err = 0;
        for (int i = 0; i < NPID; i++) begin
            if (t_vld[i] && t_pid[i] == m_pid && slot < 0) slot = i;
            if (!t_vld[i] && fr < 0) fr = i;
        end
        if (m_pid != 13'h1FFF && !m_tei) begin
            if (slot >= 0) begin
                succ = t_cc[slot] + 4'd1;
                if (a == 2'b00 || a == 2'b10) begin
                    err = (c != t_cc[slot]);
                end else if (c == succ) begin
                    t_dup[slot] = 0;
                end else if (c == t_cc[slot]) begin
                    if (t_dup[slot]) err = 1;
                    else t_dup[slot] = 1;
                end else begin
                    err = 1;
                    t_dup[slot] = 0;
                end
                t_cc[slot] = c;
            end else if (fr >= 0) begin
                t_vld[fr] = 1; t_pid[fr] = m_pid; t_cc[fr] = c; t_dup[fr] = 0;
            end
        end
        e_hv = 1; e_ce = err; e_pid = m_pid; e_cc = c; e_afc = a;
        e_tei = m_tei; e_pusi = m_pusi;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic ps);
        if (pos < 0) begin
            if (ps && b == 8'h47) pos = 1;
        end else if (ps) begin
            if (b != 8'h47) begin
                e_sl = 1; pos = -1;
            end else begin
                e_sl = (pos != 188); pos = 1;
            end
        end else if (pos == 188) begin
            e_sl = 1; pos = -1;
        end else begin
            if (pos == 1) begin
                m_tei = b[7]; m_pusi = b[6]; m_pid[12:8] = b[4:0];
            end else if (pos == 2) begin
                m_pid[7:0] = b;
            end else if (pos == 3) begin
                model_header(b[3:0], b[5:4]);
            end
            pos++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pos = -1; m_pid = '0; m_tei = 0; m_pusi = 0;
                e_hv = 0; e_ce = 0; e_sl = 0; e_tei = 0; e_pusi = 0;
                e_pid = '0; e_cc = '0; e_afc = '0;
                e_pkt = '0; e_cerr = '0; e_tcnt = '0;
                for (int i = 0; i < NPID; i++) t_vld[i] = 0;
            end else begin
                if (cnt_clr) begin
                    e_pkt = '0; e_cerr = '0; e_tcnt = '0;
                end else begin
                    if (e_hv) e_pkt = sinc(e_pkt);
                    if (e_hv && e_tei) e_tcnt = sinc(e_tcnt);
                    if (e_ce) e_cerr = sinc(e_cerr);
                end
                e_hv = 0; e_ce = 0; e_sl = 0;
                if (byte_valid) model_byte(byte_in, pkt_start);
                if (cnt_clr)
                    for (int i = 0; i < NPID; i++) t_vld[i] = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("hdr_valid", hdr_valid, e_hv);
            chk("cc_error", cc_error, e_ce);
            chk("sync_loss", sync_loss, e_sl);
            chk("pid", pid, e_pid);
            chk("cc", cc, e_cc);
            chk("afc", afc, e_afc);
            chk("tei", tei, e_tei);
            chk("pusi", pusi, e_pusi);
            chk("pkt_count", pkt_count, e_pkt);
            chk("cc_err_count", cc_err_count, e_cerr);
            chk("tei_count", tei_count, e_tcnt);
            if (hdr_valid) n_hv++;
            if (cc_error) n_ce++;
            if (sync_loss) n_sl++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic bv, input logic ps, input logic [7:0] b);
        byte_valid = bv; pkt_start = ps; byte_in = b;
        cnt_clr = rnd_clr && ($urandom_range(0, 299) == 0);
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ps);
        while (gaps && $urandom_range(0, 3) == 0) cyc(1'b0, 1'($urandom), 8'($urandom));
        cyc(1'b1, ps, b);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'd0);
    endtask

    task automatic clr_pulse();
        byte_valid = 0; pkt_start = 0; cnt_clr = 1;
        @(negedge clk);
        cnt_clr = 0;
    endtask

    task automatic send_pkt(input logic [12:0] p, input logic t, input logic pu,
                            input logic [1:0] a, input logic [3:0] c, input int len);
        logic [7:0] hb [4];
        hb[0] = 8'h47; hb[1] = {t, pu, 1'b0, p[12:8]}; hb[2] = p[7:0]; hb[3] = {2'b00, a, c};
        for (int i = 0; i < len; i++) begin
            if (i < 4) send_byte(hb[i], i == 0);
            else send_byte(($urandom_range(0, 15) == 0) ? 8'h47 : 8'($urandom), 1'b0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    int hv0, ce0, sl0, pi, r, len;
    logic [12:0] pool [6];
    logic [3:0]  lastc [6];
    logic [12:0] p;
    logic [3:0]  c;

    initial begin
        pool[0] = 13'h100; pool[1] = 13'h101; pool[2] = 13'h1FFF;
        pool[3] = 13'h0AB; pool[4] = 13'h1234; pool[5] = 13'h005;
        for (int i = 0; i < 6; i++) lastc[i] = 4'd0;

        repeat (3) @(negedge clk);
        chk("reset_hdr_valid", hdr_valid, 0);
        chk("reset_pid", pid, 0);
        chk("reset_sync_loss", sync_loss, 0);
        chk("reset_pkt_count", pkt_count, 0);
        rst = 1'b1;
        @(negedge clk);

        // three in-sequence packets on PID 0x100
        hv0 = n_hv;
        for (int k = 0; k < 3; k++) send_pkt(13'h100, 0, 1, 2'b01, 4'(k), 188);
        idle(3);
        chk("seq3_hdr_pulses", n_hv - hv0, 3);
        chk("seq3_pkt_count", pkt_count, 3);
        chk("seq3_cc_err_count", cc_err_count, 0);

        // duplicate handling 5,5,5 then wrap 15 -> 0
        clr_pulse();
        ce0 = n_ce;
        send_pkt(13'h100, 0, 0, 2'b01, 4'd5, 188);
        send_pkt(13'h100, 0, 0, 2'b01, 4'd5, 188);
        idle(3);
        chk("dup_first_ok", n_ce - ce0, 0);
        send_pkt(13'h100, 0, 0, 2'b01, 4'd5, 188);
        idle(3);
        chk("dup_second_err", n_ce - ce0, 1);
        chk("dup_cc_err_count", cc_err_count, 1);
        clr_pulse();
        ce0 = n_ce;
        send_pkt(13'h100, 0, 0, 2'b01, 4'd15, 188);
        send_pkt(13'h100, 0, 0, 2'b01, 4'd0, 188);
        idle(3);
        chk("wrap_no_err", n_ce - ce0, 0);

        // abort in payload at byte index 100, then normal packet
        clr_pulse();
        hv0 = n_hv; ce0 = n_ce; sl0 = n_sl;
        send_pkt(13'h101, 0, 0, 2'b01, 4'd0, 100);
        send_pkt(13'h101, 0, 0, 2'b01, 4'd1, 188);
        idle(3);
        chk("abort100_sync_loss", n_sl - sl0, 1);
        chk("abort100_hdr_pulses", n_hv - hv0, 2);
        chk("abort100_next_pid", pid, 13'h101);
        chk("abort100_next_cc", cc, 1);
        chk("abort100_no_cc_err", n_ce - ce0, 0);
        // abort during header bytes: no header for the aborted packet
        hv0 = n_hv; sl0 = n_sl;
        send_pkt(13'h101, 0, 0, 2'b01, 4'd2, 2);
        send_pkt(13'h101, 0, 0, 2'b01, 4'd2, 188);
        idle(3);
        chk("aborthdr_sync_loss", n_sl - sl0, 1);
        chk("aborthdr_hdr_pulses", n_hv - hv0, 1);

        // full table, then untracked PID and null PID never flag errors
        clr_pulse();
        ce0 = n_ce;
        for (int k = 1; k <= 9; k++) send_pkt(13'(k), 0, 0, 2'b01, 4'd0, 188);
        send_pkt(13'd9, 0, 0, 2'b01, 4'd7, 188);
        send_pkt(13'h1FFF, 0, 0, 2'b01, 4'($urandom), 188);
        send_pkt(13'h1FFF, 0, 0, 2'b01, 4'($urandom), 188);
        idle(3);
        chk("tablefull_no_err", n_ce - ce0, 0);
        send_pkt(13'd1, 0, 0, 2'b01, 4'd7, 188);
        idle(3);
        chk("tracked_pid_err", n_ce - ce0, 1);

        // transport-error header 47 80 10 13
        clr_pulse();
        ce0 = n_ce;
        send_pkt(13'h010, 1, 0, 2'b01, 4'd3, 188);
        idle(3);
        chk("tei_flag", tei, 1);
        chk("tei_pid", pid, 13'h010);
        chk("tei_afc", afc, 1);
        chk("tei_cc", cc, 3);
        chk("tei_count", tei_count, 1);
        send_pkt(13'h010, 0, 0, 2'b01, 4'd9, 188);
        send_pkt(13'h010, 0, 0, 2'b01, 4'd11, 188);
        idle(3);
        chk("tei_table_untouched", n_ce - ce0, 1);

        // missing sync after byte 187, then reset mid-payload
        sl0 = n_sl;
        send_pkt(13'h102, 0, 0, 2'b01, 4'd0, 188);
        send_byte(8'h00, 1'b0);
        send_byte(8'h47, 1'b0);
        send_byte(8'h12, 1'b0);
        idle(2);
        chk("nosync_sync_loss", n_sl - sl0, 1);
        send_pkt(13'h102, 0, 0, 2'b01, 4'd1, 50);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_pkt_count", pkt_count, 0);
        chk("midrst_cc_err_count", cc_err_count, 0);
        chk("midrst_tei_count", tei_count, 0);
        chk("midrst_pid", pid, 0);
        chk("midrst_hdr_valid", hdr_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        hv0 = n_hv; ce0 = n_ce;
        for (int k = 0; k < 30; k++) send_byte(8'($urandom), 1'b0);
        send_pkt(13'h102, 0, 0, 2'b01, 4'd6, 188);
        idle(3);
        chk("postrst_hdr_pulses", n_hv - hv0, 1);
        chk("postrst_no_cc_err", n_ce - ce0, 0);

        // counter saturation with short aborted packets
        clr_pulse();
        for (int k = 0; k < 17; k++) send_pkt(13'h103, 0, 0, 2'b01, 4'(k), 4);
        idle(3);
        chk("sat_pkt_count", pkt_count, CMAX);

        // randomized packet stream
        gaps = 1; rnd_clr = 1;
        for (int k = 0; k < 60; k++) begin
            pi = $urandom_range(0, 5);
            p  = ($urandom_range(0, 9) == 0) ? 13'($urandom) : pool[pi];
            r  = $urandom_range(0, 9);
            if (r < 6) c = lastc[pi] + 4'd1;
            else if (r < 8) c = lastc[pi];
            else c = 4'($urandom);
            lastc[pi] = c;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 187) : 188;
            send_pkt(p, $urandom_range(0, 9) == 0, 1'($urandom), 2'($urandom), c, len);
            if ($urandom_range(0, 14) == 0)
                repeat ($urandom_range(1, 4)) send_byte(8'($urandom), 1'($urandom));
        end
        gaps = 0; rnd_clr = 0;
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
